lfsr_rand_gen: RTL and testbench

- Parametrised Fibonacci LFSR random source, the successor to the fixed 15-bit free-running LFSR.
- Adds configurable width, runtime seed load, a step enable and zero-lockup protection.
- Adds a valid/ready output stage that emits uniformly distributed values in [0, RANGE-1] by rejection sampling.
- Feeds the piece-select logic in the game core; the default RANGE=7 gives one value per tetromino.

---
 rtl/lfsr_pkg.sv | 50 +++++
 rtl/lfsr_rand_gen_if.sv | 11 +
 rtl/lfsr_core.sv | 53 +++++
 rtl/lfsr_rand_gen.sv | 122 ++++++++++++
 tb/tb_lfsr_rand_gen.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR random source: width limits, tap table and output-stage states.
// Optional build macro used by the top level: LFSR_NO_REPEAT_EN.
package lfsr_pkg;

    localparam int unsigned MIN_W = 8;
    localparam int unsigned MAX_W = 32;

    typedef enum logic {IDLE_S, HOLD_S} out_state_e;

    // Tap n of the characteristic polynomial maps to register bit n-1.
    function automatic logic [MAX_W-1:0] tap_bit(input int unsigned n);
        return MAX_W'(1) << (n - 1);
    endfunction

    // Maximal-length feedback masks for WIDTH = MIN_W..MAX_W.
    function automatic logic [MAX_W-1:0] taps_for(input int unsigned width);
        logic [MAX_W-1:0] m;
        m = '0;
        case (width)
            8:       m = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
            9:       m = tap_bit(9)  | tap_bit(5);
            10:      m = tap_bit(10) | tap_bit(7);
            11:      m = tap_bit(11) | tap_bit(9);
            12:      m = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            13:      m = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
            14:      m = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
            15:      m = tap_bit(15) | tap_bit(14);
            16:      m = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
            17:      m = tap_bit(17) | tap_bit(14);
            18:      m = tap_bit(18) | tap_bit(11);
            19:      m = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            20:      m = tap_bit(20) | tap_bit(17);
            21:      m = tap_bit(21) | tap_bit(19);
            22:      m = tap_bit(22) | tap_bit(21);
            23:      m = tap_bit(23) | tap_bit(18);
            24:      m = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
            25:      m = tap_bit(25) | tap_bit(22);
            26:      m = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
            27:      m = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
            28:      m = tap_bit(28) | tap_bit(25);
            29:      m = tap_bit(29) | tap_bit(27);
            30:      m = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
            31:      m = tap_bit(31) | tap_bit(28);
            32:      m = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
            default: m = tap_bit(15) | tap_bit(14);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Valid/ready sample channel between the random source (master) and its consumer (slave).
interface lfsr_rand_gen_if #(
    parameter int unsigned OUT_W = 3
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_value;

    modport master (output out_valid, output out_value, input out_ready);
    modport slave  (input out_valid, input out_value, output out_ready);
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR with seed load, step enable and zero-seed correction.
// Also exposes the low bits of the next state so samples are taken on the shifting edge.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 15,
    parameter int unsigned      OUT_W = 3,
    parameter logic [WIDTH-1:0] RST_STATE = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_step_en,
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed_in,
    output logic [WIDTH-1:0] o_state,
    output logic [OUT_W-1:0] o_cand,
    output logic             o_shift,
    output logic             o_lockup_err
);
    localparam logic [MAX_W-1:0] TapsFull = taps_for(WIDTH);
    localparam logic [WIDTH-1:0] Taps     = TapsFull[WIDTH-1:0];

    logic [WIDTH-1:0] r_state;
    logic             r_lockup;
    logic             w_fb;
    logic             w_seed_zero;
    logic [WIDTH-1:0] w_next;

    assign w_fb        = ^(r_state & Taps);
    assign w_next      = {r_state[WIDTH-2:0], w_fb};
    assign w_seed_zero = (i_seed_in == '0);

    assign o_state      = r_state;
    assign o_cand       = w_next[OUT_W-1:0];
    assign o_shift      = i_step_en & ~i_seed_load;
    assign o_lockup_err = r_lockup;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= RST_STATE;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= i_seed_load & w_seed_zero;
            if (i_seed_load) begin
                // An all-zero state never leaves zero, so force it to 1.
                r_state <= w_seed_zero ? WIDTH'(1) : i_seed_in;
            end else if (i_step_en) begin
                r_state <= w_next;
            end
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// LFSR random source with a rejection-sampled valid/ready output in [0, RANGE-1].
// Build macro LFSR_NO_REPEAT_EN: reject a candidate equal to the last accepted value once.
module lfsr_rand_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH = 15,
    parameter int unsigned OUT_W = 3,
    parameter int unsigned RANGE = 7,
    parameter logic [31:0] SEED  = 32'h1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    step_en,
    input  logic                    seed_load,
    input  logic [WIDTH-1:0]        seed_in,
    lfsr_rand_gen_if.master         out_if,
    output logic [WIDTH-1:0]        lfsr_state,
    output logic                    lockup_err
);
    localparam logic [WIDTH-1:0] SeedW    = SEED[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RstState = (SeedW == '0) ? WIDTH'(1) : SeedW;
    localparam int unsigned      CntW     = (OUT_W < 2) ? 1 : $clog2(OUT_W);
    localparam logic [CntW-1:0]  CntLast  = CntW'(OUT_W - 1);
    localparam logic [OUT_W:0]   RangeW   = (OUT_W + 1)'(RANGE);

    out_state_e       r_ostate;
    logic [OUT_W-1:0] r_value;
    logic [CntW-1:0]  r_cnt;

    logic [OUT_W-1:0] w_cand;
    logic             w_shift;
    logic             w_wrap;
    logic             w_in_range;
    logic             w_free;
    logic             w_repeat;
    logic             w_take;

    lfsr_core #(
        .WIDTH     (WIDTH),
        .OUT_W     (OUT_W),
        .RST_STATE (RstState)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_step_en    (step_en),
        .i_seed_load  (seed_load),
        .i_seed_in    (seed_in),
        .o_state      (lfsr_state),
        .o_cand       (w_cand),
        .o_shift      (w_shift),
        .o_lockup_err (lockup_err)
    );

    assign w_wrap     = w_shift && (r_cnt == CntLast);
    assign w_in_range = ({1'b0, w_cand} < RangeW);
    // A held sample being accepted this edge frees the slot for a new candidate.
    assign w_free     = (r_ostate == IDLE_S) || out_if.out_ready;
    assign w_take     = w_wrap && w_in_range && w_free && !w_repeat;

`ifdef LFSR_NO_REPEAT_EN
    logic [OUT_W-1:0] r_last;
    logic             r_last_vld;
    logic             r_rerolled;

    assign w_repeat = r_last_vld && (w_cand == r_last) && !r_rerolled;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_rerolled <= 1'b0;
        end else if (seed_load) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
            r_rerolled <= 1'b0;
        end else if (w_take) begin
            r_last     <= w_cand;
            r_last_vld <= 1'b1;
            r_rerolled <= 1'b0;
        end else if (w_wrap && w_in_range && w_free && w_repeat) begin
            r_rerolled <= 1'b1;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ostate <= IDLE_S;
            r_value  <= '0;
            r_cnt    <= '0;
        end else if (seed_load) begin
            r_ostate <= IDLE_S;
            r_cnt    <= '0;
        end else begin
            if (w_shift) begin
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            end
            case (r_ostate)
                IDLE_S: begin
                    if (w_take) begin
                        r_ostate <= HOLD_S;
                        r_value  <= w_cand;
                    end
                end
                HOLD_S: begin
                    if (w_take) begin
                        r_value <= w_cand;
                    end else if (out_if.out_ready) begin
                        r_ostate <= IDLE_S;
                    end
                end
                default: r_ostate <= IDLE_S;
            endcase
        end
    end

    assign out_if.out_valid = (r_ostate == HOLD_S);
    assign out_if.out_value = r_value;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen (WIDTH=15, OUT_W=3, RANGE=7, SEED=1) with hand-derived values.
module tb_lfsr_rand_gen;
    logic        clk;
    logic        reset_n;
    logic        step_en;
    logic        seed_load;
    logic [14:0] seed_in;
    logic [14:0] lfsr_state;
    logic        lockup_err;

    int n_tests;
    int n_fail;

    lfsr_rand_gen_if #(.OUT_W(3)) out_if ();

    lfsr_rand_gen #(
        .WIDTH (15),
        .OUT_W (3),
        .RANGE (7),
        .SEED  (32'h1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .step_en    (step_en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .out_if     (out_if),
        .lfsr_state (lfsr_state),
        .lockup_err (lockup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [14:0] s);
        seed_in   = s;
        seed_load = 1'b1;
        tick(1);
        seed_load = 1'b0;
    endtask

    initial begin
        int hits;
        int bad;
        n_tests = 0;
        n_fail  = 0;
        reset_n = 1'b0;
        step_en = 1'b0;
        seed_load = 1'b0;
        seed_in = '0;
        out_if.out_ready = 1'b1;

        #12;
        check_eq("rst_state", 32'(lfsr_state), 32'h1);
        check_eq("rst_valid", 32'(out_if.out_valid), 32'h0);
        check_eq("rst_value", 32'(out_if.out_value), 32'h0);
        check_eq("rst_lockup", 32'(lockup_err), 32'h0);

        // Free stepping from reset.
        reset_n = 1'b1;
        step_en = 1'b1;
        tick(1);
        check_eq("e1_state", 32'(lfsr_state), 32'h2);
        check_eq("e1_valid", 32'(out_if.out_valid), 32'h0);
        tick(1);
        check_eq("e2_state", 32'(lfsr_state), 32'h4);
        tick(1);
        check_eq("e3_state", 32'(lfsr_state), 32'h8);
        check_eq("e3_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("e3_value", 32'(out_if.out_value), 32'h0);
        tick(11);
        check_eq("e14_state", 32'(lfsr_state), 32'h4001);
        check_eq("e14_valid", 32'(out_if.out_valid), 32'h0);
        tick(1);
        check_eq("e15_state", 32'(lfsr_state), 32'h0003);
        check_eq("e15_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("e15_value", 32'(out_if.out_value), 32'h3);

        // Seed load beats step_en and discards the pending sample; candidate 7 is rejected.
        load_seed(15'h5000);
        check_eq("seed_state", 32'(lfsr_state), 32'h5000);
        check_eq("seed_valid", 32'(out_if.out_valid), 32'h0);
        check_eq("seed_lockup", 32'(lockup_err), 32'h0);
        tick(3);
        check_eq("rej_state", 32'(lfsr_state), 32'h0007);
        check_eq("rej_valid", 32'(out_if.out_valid), 32'h0);
        tick(3);
        check_eq("acc_state", 32'(lfsr_state), 32'h0038);
        check_eq("acc_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("acc_value", 32'(out_if.out_value), 32'h0);

        // Zero seed is corrected and flagged for one cycle.
        step_en = 1'b0;
        load_seed(15'h0000);
        check_eq("zero_state", 32'(lfsr_state), 32'h1);
        check_eq("zero_lockup", 32'(lockup_err), 32'h1);
        check_eq("zero_valid", 32'(out_if.out_valid), 32'h0);
        tick(1);
        check_eq("zero_lockup_end", 32'(lockup_err), 32'h0);
        check_eq("zero_hold", 32'(lfsr_state), 32'h1);

        // step_en low mid-count freezes everything.
        step_en = 1'b1;
        tick(2);
        check_eq("frz_pre_state", 32'(lfsr_state), 32'h4);
        step_en = 1'b0;
        tick(5);
        check_eq("frz_state", 32'(lfsr_state), 32'h4);
        check_eq("frz_valid", 32'(out_if.out_valid), 32'h0);
        step_en = 1'b1;
        tick(1);
        check_eq("frz_res_state", 32'(lfsr_state), 32'h8);
        check_eq("frz_res_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("frz_res_value", 32'(out_if.out_value), 32'h0);

        // Backpressure: sample held for 10 cycles while the LFSR advances.
        out_if.out_ready = 1'b0;
        load_seed(15'h0001);
        tick(3);
        check_eq("bp_first_valid", 32'(out_if.out_valid), 32'h1);
        tick(5);
        check_eq("bp_mid_state", 32'(lfsr_state), 32'h0100);
        check_eq("bp_mid_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("bp_mid_value", 32'(out_if.out_value), 32'h0);
        tick(5);
        check_eq("bp_end_state", 32'(lfsr_state), 32'h2000);
        check_eq("bp_end_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("bp_end_value", 32'(out_if.out_value), 32'h0);
        out_if.out_ready = 1'b1;
        tick(1);
        check_eq("bp_acc_valid", 32'(out_if.out_valid), 32'h0);
        check_eq("bp_acc_state", 32'(lfsr_state), 32'h4001);
        tick(1);
        check_eq("bp_next_valid", 32'(out_if.out_valid), 32'h1);
        check_eq("bp_next_value", 32'(out_if.out_value), 32'h3);

        // Full period: state 1 reappears exactly once; every sample is in range.
        load_seed(15'h0001);
        hits = 0;
        bad  = 0;
        for (int k = 0; k < 32767; k++) begin
            tick(1);
            if (lfsr_state == 15'h0001) hits++;
            if (out_if.out_valid && (out_if.out_value >= 3'd7)) bad++;
        end
        check_eq("period_hits", 32'(hits), 32'd1);
        check_eq("period_final", 32'(lfsr_state), 32'h1);
        check_eq("range_bad", 32'(bad), 32'd0);

        // Asynchronous reset mid-operation.
        out_if.out_ready = 1'b0;
        load_seed(15'h0001);
        tick(3);
        check_eq("pre_rst_valid", 32'(out_if.out_valid), 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("arst_state", 32'(lfsr_state), 32'h1);
        check_eq("arst_valid", 32'(out_if.out_valid), 32'h0);
        check_eq("arst_lockup", 32'(lockup_err), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
